wb_spram_bridge: RTL and testbench

// - Wishbone-classic slave that sits directly downstream of the SPI-to-Wishbone master.
// - Maps 32-bit Wishbone accesses onto one 16-bit single-port RAM (iCE40 SPRAM style) as two half-word accesses.
// - Tolerates a master that holds stb for one cycle only and then holds cyc until ack.
// - Out-of-window addresses are acked with a fixed pattern so the master never hangs.

---
 rtl/wb_bridge_pkg.sv | 20 ++
 rtl/wb_spram_bridge.sv | 138 +++++++++++++
 tb/tb_wb_spram_bridge.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_bridge_pkg.sv
// Shared definitions for the Wishbone-to-SPRAM bridge.
//   state_t  : bridge FSM states
//   WB_ADR_W : Wishbone byte-address width
//   WB_DAT_W : Wishbone data width
package wb_bridge_pkg;

  localparam int WB_ADR_W = 24;
  localparam int WB_DAT_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WR_LO  = 3'd1,
    WR_HI  = 3'd2,
    RD_LO  = 3'd3,
    RD_HI  = 3'd4,
    RD_END = 3'd5,
    ACK    = 3'd6
  } state_t;

endpackage

// File: rtl/wb_spram_bridge.sv
// Wishbone-classic slave mapping 32-bit accesses onto a 16-bit single-port
// RAM as two half-word accesses (low half first). Out-of-window accesses are
// acked after one cycle; reads return MISS_DAT, writes are dropped.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   i_wb_cyc/stb/we/adr/dat  Wishbone request (stb sampled only in IDLE)
//   o_wb_ack, o_wb_dat    registered one-cycle ack and read data
//   o_mem_cs/we/adr/wdat  RAM control, half-word address, write data
//   i_mem_rdat            RAM read data, one cycle after cs & ~we
//   o_busy                FSM not in IDLE
module wb_spram_bridge
  import wb_bridge_pkg::*;
#(
  parameter int                   MEM_AW   = 14,
  parameter logic [WB_ADR_W-1:0]  BASE_ADR = 24'h000000,
  parameter logic [WB_DAT_W-1:0]  MISS_DAT = 32'hDEADBEEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wb_cyc,
  input  logic                i_wb_stb,
  input  logic                i_wb_we,
  input  logic [WB_ADR_W-1:0] i_wb_adr,
  input  logic [WB_DAT_W-1:0] i_wb_dat,
  output logic                o_wb_ack,
  output logic [WB_DAT_W-1:0] o_wb_dat,
  output logic                o_mem_cs,
  output logic                o_mem_we,
  output logic [MEM_AW-1:0]   o_mem_adr,
  output logic [15:0]         o_mem_wdat,
  input  logic [15:0]         i_mem_rdat,
  output logic                o_busy
);

  state_t            state;
  logic [MEM_AW-2:0] word_q;
  logic [15:0]       dat_hi_q;
  logic              mem_cs_q;
  logic              mem_we_q;
  logic              hit;
  logic              unused_adr;

  assign hit        = (i_wb_adr[WB_ADR_W-1:MEM_AW+1] == BASE_ADR[WB_ADR_W-1:MEM_AW+1]);
  assign unused_adr = ^i_wb_adr[1:0];
  assign o_busy     = (state != IDLE);

  // The RAM strobe is qualified by cyc so that dropping cyc suppresses the
  // access of that very cycle (an abort in WR_HI leaves only the low half).
  assign o_mem_cs = mem_cs_q & i_wb_cyc;
  assign o_mem_we = mem_we_q & i_wb_cyc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_q     <= '0;
      dat_hi_q   <= '0;
      mem_cs_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      o_mem_adr  <= '0;
      o_mem_wdat <= '0;
      o_wb_ack   <= 1'b0;
      o_wb_dat   <= '0;
    end else begin
      o_wb_ack <= 1'b0;
      mem_cs_q <= 1'b0;
      mem_we_q <= 1'b0;
      case (state)
        IDLE: begin
          if (i_wb_cyc && i_wb_stb) begin
            word_q   <= i_wb_adr[MEM_AW:2];
            dat_hi_q <= i_wb_dat[31:16];
            if (hit) begin
              // Outputs for the first half-word are set up on entry.
              mem_cs_q   <= 1'b1;
              mem_we_q   <= i_wb_we;
              o_mem_adr  <= {i_wb_adr[MEM_AW:2], 1'b0};
              o_mem_wdat <= i_wb_dat[15:0];
              state      <= i_wb_we ? WR_LO : RD_LO;
            end else begin
              o_wb_ack <= 1'b1;
              if (!i_wb_we) o_wb_dat <= MISS_DAT;
              state <= ACK;
            end
          end
        end
        WR_LO: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            mem_cs_q   <= 1'b1;
            mem_we_q   <= 1'b1;
            o_mem_adr  <= {word_q, 1'b1};
            o_mem_wdat <= dat_hi_q;
            state      <= WR_HI;
          end
        end
        WR_HI: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            o_wb_ack <= 1'b1;
            state    <= ACK;
          end
        end
        RD_LO: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            mem_cs_q  <= 1'b1;
            o_mem_adr <= {word_q, 1'b1};
            state     <= RD_HI;
          end
        end
        RD_HI: begin
          // Low half-word from the RD_LO access is on i_mem_rdat now.
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            o_wb_dat[15:0] <= i_mem_rdat;
            state          <= RD_END;
          end
        end
        RD_END: begin
          if (!i_wb_cyc) begin
            state <= IDLE;
          end else begin
            o_wb_dat[31:16] <= i_mem_rdat;
            o_wb_ack        <= 1'b1;
            state           <= ACK;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_spram_bridge.sv
// Bench for wb_spram_bridge: a one-cycle-stb Wishbone master, a 16-bit SPRAM
// model, and a scoreboard fed by the driver and drained by an ack monitor.
module spram_model #(
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          cs,
  input  logic          we,
  input  logic [AW-1:0] adr,
  input  logic [15:0]   wdat,
  output logic [15:0]   rdat
);
  logic [15:0] mem [0:(1<<AW)-1];

  initial begin
    rdat = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
  end

  always @(posedge clk) begin
    if (cs) begin
      if (we) mem[adr] <= wdat;
      else    rdat     <= mem[adr];
    end
  end
endmodule

module tb_wb_spram_bridge;

  localparam int          MEM_AW   = 14;
  localparam logic [23:0] BASE_ADR = 24'h000000;
  localparam logic [31:0] MISS_DAT = 32'hDEADBEEF;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [23:0]        wb_adr = '0;
  logic [31:0]        wb_wdat = '0;
  logic               wb_ack;
  logic [31:0]        wb_rdat;
  logic               mem_cs, mem_we, busy;
  logic [MEM_AW-1:0]  mem_adr;
  logic [15:0]        mem_wdat, mem_rdat;

  always #5 clk = ~clk;

  wb_spram_bridge #(
    .MEM_AW  (MEM_AW),
    .BASE_ADR(BASE_ADR),
    .MISS_DAT(MISS_DAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wb_cyc  (wb_cyc),
    .i_wb_stb  (wb_stb),
    .i_wb_we   (wb_we),
    .i_wb_adr  (wb_adr),
    .i_wb_dat  (wb_wdat),
    .o_wb_ack  (wb_ack),
    .o_wb_dat  (wb_rdat),
    .o_mem_cs  (mem_cs),
    .o_mem_we  (mem_we),
    .o_mem_adr (mem_adr),
    .o_mem_wdat(mem_wdat),
    .i_mem_rdat(mem_rdat),
    .o_busy    (busy)
  );

  spram_model #(.AW(MEM_AW)) ram (
    .clk (clk),
    .cs  (mem_cs),
    .we  (mem_we),
    .adr (mem_adr),
    .wdat(mem_wdat),
    .rdat(mem_rdat)
  );

  typedef struct {
    logic        is_read;
    logic [31:0] dat;
    int unsigned lat;
    int unsigned cs_n;
    int unsigned we_n;
    int unsigned start;
    int unsigned cs0;
    int unsigned we0;
  } item_t;

  item_t       sb[$];
  int unsigned total = 0, bad = 0;
  int unsigned cnum = 0, cs_tot = 0, we_tot = 0;
  logic [15:0] bmem [int unsigned];

  always @(posedge clk) cnum <= cnum + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: byte address -> window hit and half-word index.
  function automatic logic in_window(input logic [23:0] adr);
    return (adr >> (MEM_AW + 1)) == (BASE_ADR >> (MEM_AW + 1));
  endfunction

  function automatic int unsigned hidx(input logic [23:0] adr, input int unsigned half);
    int unsigned word;
    word = (int'(adr) >> 2) & ((1 << (MEM_AW - 1)) - 1);
    return word * 2 + half;
  endfunction

  function automatic logic [15:0] bget(input int unsigned i);
    return bmem.exists(i) ? bmem[i] : 16'h0000;
  endfunction

  // Monitor: every ack consumes one scoreboard entry.
  always @(negedge clk) begin
    item_t it;
    if (mem_cs) cs_tot++;
    if (mem_cs && mem_we) we_tot++;
    if (wb_ack) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_ack: got ack=1 expected no pending request (t=%0t)", $time);
      end else begin
        it = sb.pop_front();
        chk("ack_latency", 64'(cnum - it.start), 64'(it.lat));
        chk("mem_cs_cycles", 64'(cs_tot - it.cs0), 64'(it.cs_n));
        chk("mem_we_cycles", 64'(we_tot - it.we0), 64'(it.we_n));
        if (it.is_read) chk("read_data", 64'(wb_rdat), 64'(it.dat));
      end
    end
  end

  task automatic xact(input logic we, input logic [23:0] adr, input logic [31:0] dat);
    item_t it;
    logic  hit;
    bit    got;
    @(negedge clk);
    hit        = in_window(adr);
    it.is_read = !we;
    it.dat     = hit ? {bget(hidx(adr, 1)), bget(hidx(adr, 0))} : MISS_DAT;
    it.lat     = !hit ? 1 : (we ? 3 : 4);
    it.cs_n    = hit ? 2 : 0;
    it.we_n    = (hit && we) ? 2 : 0;
    it.start   = cnum;
    it.cs0     = cs_tot;
    it.we0     = we_tot;
    sb.push_back(it);
    if (hit && we) begin
      bmem[hidx(adr, 0)] = dat[15:0];
      bmem[hidx(adr, 1)] = dat[31:16];
    end
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_wdat = dat;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      wb_stb = 1'b0;
      if (wb_ack) got = 1;
    end
    wb_cyc = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ack_timeout: got no ack expected ack for adr %0h", adr);
      void'(sb.pop_back());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] a;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 64'({wb_ack, wb_rdat, mem_cs, mem_we, mem_adr, mem_wdat, busy}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed write then read-back (back-to-back master).
    xact(1'b1, 24'h000010, 32'hCAFEF00D);
    chk("mem_lo_0008", 64'(ram.mem[8]), 64'h0000F00D);
    chk("mem_hi_0009", 64'(ram.mem[9]), 64'h0000CAFE);
    xact(1'b0, 24'h000010, 32'h0);

    // Miss read and miss write, and the first address past the window.
    xact(1'b0, 24'h800000, 32'h0);
    xact(1'b1, 24'h008000, 32'h11112222);
    xact(1'b0, 24'h008000, 32'h0);

    // Last word of the window.
    xact(1'b1, 24'h007FFC, 32'h5A5AA5A5);
    chk("mem_top_lo", 64'(ram.mem[16'h3FFE]), 64'h0000A5A5);
    xact(1'b0, 24'h007FFF, 32'h0);

    // Abort a write by dropping cyc during WR_HI.
    xact(1'b1, 24'h000040, 32'hAAAABBBB);
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b1; wb_adr = 24'h000040; wb_wdat = 32'h12345678;
    @(negedge clk);
    wb_stb = 1'b0;
    @(negedge clk);
    wb_cyc = 1'b0;
    bmem[hidx(24'h000040, 0)] = 16'h5678;
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_lo", 64'(ram.mem[16'h0020]), 64'h00005678);
    chk("abort_hi", 64'(ram.mem[16'h0021]), 64'h0000AAAA);
    xact(1'b0, 24'h000040, 32'h0);

    // Asynchronous reset while in RD_HI.
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 24'h000010;
    @(negedge clk);
    wb_stb = 1'b0;
    @(negedge clk);
    chk("rd_hi_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 64'({wb_ack, wb_rdat, mem_cs, mem_we, mem_adr, mem_wdat, busy}), 64'd0);
    wb_cyc = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xact(1'b0, 24'h000010, 32'h0);

    // Randomized traffic over a small set of words plus occasional misses.
    for (int n = 0; n < 60; n++) begin
      a = 24'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) a = a | 24'h800000 | 24'($urandom & 32'h007FFFFF);
      xact(1'($urandom_range(0, 1)), a, $urandom);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
